// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its PLL / reset consumers.
// Optional loss-counter signals exist only when PLL_LOSS_COUNTER_EN is defined.
interface pll_reset_sequencer_if #(
    parameter int unsigned N_DOMAINS = 3
);
    logic                 pll_locked;
    logic                 pll_rst;
    logic [N_DOMAINS-1:0] domain_rst;
    logic                 ready;
    logic                 relock_req;
    logic                 relock_ack;
    logic [2:0]           state;
    logic [3:0]           retry_cnt;
`ifdef PLL_LOSS_COUNTER_EN
    logic [7:0]           loss_cnt;
    logic                 lock_lost_sticky;
`endif

`ifdef PLL_LOSS_COUNTER_EN
    // Sequencer side.
    modport master (
        input  pll_locked, relock_req,
        output pll_rst, domain_rst, ready, relock_ack, state, retry_cnt,
        output loss_cnt, lock_lost_sticky
    );
    // PLL / requester / reset-consumer side.
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, domain_rst, ready, relock_ack, state, retry_cnt,
        input  loss_cnt, lock_lost_sticky
    );
`else
    // Sequencer side.
    modport master (
        input  pll_locked, relock_req,
        output pll_rst, domain_rst, ready, relock_ack, state, retry_cnt
    );
    // PLL / requester / reset-consumer side.
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, domain_rst, ready, relock_ack, state, retry_cnt
    );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases the
// downstream domain resets in order (bit 0 first). Lock loss or a relock request
// in RUN re-asserts every domain reset and restarts bring-up.
// Optional feature macro: PLL_LOSS_COUNTER_EN (adds loss_cnt / lock_lost_sticky).
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned RELEASE_GAP    = 64,
    parameter int unsigned N_DOMAINS      = 3
) (
    input logic                    refclk,
    input logic                    rst,
    pll_reset_sequencer_if.master  bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Cycle of RELEASE on which the last domain bit has already cleared.
    localparam int unsigned RelEnd = (N_DOMAINS - 1) * RELEASE_GAP;
    localparam int unsigned CntMax = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                          max2(LOCK_STABLE, RelEnd + 1));
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4
    } state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [CntW-1:0]      cnt_inc;
    logic                 sync_q;
    logic                 locked_s;
    logic                 pll_rst_q;
    logic [N_DOMAINS-1:0] domain_rst_q;
    logic [N_DOMAINS-1:0] rel_mask;
    logic                 ready_q;
    logic                 ack_q;
    logic [3:0]           retry_q;
    logic                 pending_q;
    logic                 relock_hit;
    logic                 loss_evt;

    // Two-flop synchronizer for the asynchronous raw lock.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= bus.pll_locked;
            locked_s <= sync_q;
        end
    end

    // Release mask and event decode for the sequencing FSM.
    always_comb begin
        cnt_inc  = cnt_q + CntW'(1);
        rel_mask = '0;
        rel_mask[0] = 1'b1;
        for (int k = 1; k < int'(N_DOMAINS); k++) begin
            rel_mask[k] = (32'(cnt_inc) >= (k * RELEASE_GAP));
        end
        // The request is still high during the ack cycle; it only counts after that.
        relock_hit = (state_q == StRun) && bus.relock_req && !ack_q;
        // Unrequested lock loss while domains are (being) released.
        loss_evt   = ((state_q == StRelease) || (state_q == StRun)) && !locked_s && !relock_hit;
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            ack_q        <= 1'b0;
            retry_q      <= 4'd0;
            pending_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StPllRst: begin
                    if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
                        state_q   <= StWaitLock;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
                        state_q   <= StPllRst;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q != 4'hF) begin
                            retry_q <= retry_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StStable: begin
                    if (!locked_s) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntW'(LOCK_STABLE - 1)) begin
                        // Bit 0 clears together with entry into RELEASE.
                        state_q         <= StRelease;
                        cnt_q           <= '0;
                        domain_rst_q[0] <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StRelease: begin
                    if (!locked_s) begin
                        state_q      <= StPllRst;
                        cnt_q        <= '0;
                        pll_rst_q    <= 1'b1;
                        domain_rst_q <= '1;
                    end else if (cnt_q == CntW'(RelEnd)) begin
                        state_q   <= StRun;
                        cnt_q     <= '0;
                        ready_q   <= 1'b1;
                        ack_q     <= pending_q;
                        pending_q <= 1'b0;
                    end else begin
                        cnt_q        <= cnt_inc;
                        domain_rst_q <= domain_rst_q & ~rel_mask;
                    end
                end
                StRun: begin
                    // A relock request wins over a coincident lock loss.
                    if (relock_hit || !locked_s) begin
                        state_q      <= StPllRst;
                        cnt_q        <= '0;
                        pll_rst_q    <= 1'b1;
                        domain_rst_q <= '1;
                        ready_q      <= 1'b0;
                        if (relock_hit) begin
                            pending_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= StPllRst;
                    cnt_q        <= '0;
                    pll_rst_q    <= 1'b1;
                    domain_rst_q <= '1;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOSS_COUNTER_EN
    logic [7:0] loss_cnt_q;
    logic       sticky_q;

    // Saturating count and sticky flag of unrequested lock losses.
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
            sticky_q   <= 1'b0;
        end else if (loss_evt) begin
            sticky_q <= 1'b1;
            if (loss_cnt_q != 8'hFF) begin
                loss_cnt_q <= loss_cnt_q + 8'd1;
            end
        end
    end

    assign bus.loss_cnt         = loss_cnt_q;
    assign bus.lock_lost_sticky = sticky_q;
`else
    logic unused_loss;
    assign unused_loss = loss_evt;
`endif

    assign bus.pll_rst    = pll_rst_q;
    assign bus.domain_rst = domain_rst_q;
    assign bus.ready      = ready_q;
    assign bus.relock_ack = ack_q;
    assign bus.state      = state_q;
    assign bus.retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed, table-driven bench for pll_reset_sequencer with params 4/32/8/2/3.
module tb_pll_reset_sequencer;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    pll_reset_sequencer_if #(.N_DOMAINS(3)) bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .LOCK_STABLE    (8),
        .RELEASE_GAP    (2),
        .N_DOMAINS      (3)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic       rst;
        logic       lock;
        logic       req;
        int         n;
        logic [2:0] st;
        logic       prst;
        logic [2:0] dom;
        logic       rdy;
        logic       ack;
        logic [3:0] retry;
        logic [7:0] loss;
        logic       sticky;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic l, input logic q, input int n,
                       input logic [2:0] st, input logic prst, input logic [2:0] dom,
                       input logic rdy, input logic ack, input logic [3:0] retry,
                       input logic [7:0] loss, input logic sticky);
        vec_t v;
        v = '{r, l, q, n, st, prst, dom, rdy, ack, retry, loss, sticky};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    int ack_seen;
    int prst_seen;

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;

        // Bring-up after reset, lock at cycle 10.
        add(1, 0, 0, 2,   0, 1, 3'b111, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3,   0, 1, 3'b111, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,   1, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4,   1, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2,   1, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   2, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 7,   2, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   3, 0, 3'b110, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   3, 0, 3'b110, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   3, 0, 3'b100, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2,   3, 0, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   4, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 1, 0, 5,   4, 0, 3'b000, 1, 0, 0, 0, 0);
        // Lock loss in RUN, then lock stays low: timeouts and retry saturation.
        add(0, 0, 0, 2,   4, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1,   0, 1, 3'b111, 0, 0, 0, 1, 1);
        add(0, 0, 0, 4,   1, 0, 3'b111, 0, 0, 0, 1, 1);
        add(0, 0, 0, 31,  1, 0, 3'b111, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1,   0, 1, 3'b111, 0, 0, 1, 1, 1);
        add(0, 0, 0, 3,   0, 1, 3'b111, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1,   1, 0, 3'b111, 0, 0, 1, 1, 1);
        add(0, 0, 0, 32,  0, 1, 3'b111, 0, 0, 2, 1, 1);
        add(0, 0, 0, 648, 0, 1, 3'b111, 0, 0, 15, 1, 1);
        // Fresh reset, lock glitch during STABLE.
        add(1, 1, 0, 1,   0, 1, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 10,  2, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3,   1, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2,   1, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   2, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 7,   2, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   3, 0, 3'b110, 0, 0, 0, 0, 0);
        add(0, 1, 0, 5,   4, 0, 3'b000, 1, 0, 0, 0, 0);
        // One-cycle relock request: full re-run, ack on first RUN cycle.
        add(0, 1, 1, 1,   0, 1, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 13,  3, 0, 3'b110, 0, 0, 0, 0, 0);
        add(0, 1, 0, 4,   3, 0, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   4, 0, 3'b000, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1,   4, 0, 3'b000, 1, 0, 0, 0, 0);
        // Relock, then rst in RELEASE at 110: clean restart, pending dropped.
        add(0, 1, 1, 1,   0, 1, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 13,  3, 0, 3'b110, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1,   0, 1, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 5,   2, 0, 3'b111, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8,   3, 0, 3'b110, 0, 0, 0, 0, 0);
        add(0, 1, 0, 4,   3, 0, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   4, 0, 3'b000, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            bus.pll_locked = vecs[i].lock;
            bus.relock_req = vecs[i].req;
            step(vecs[i].n);
            chk("state",      i, 32'(bus.state),      32'(vecs[i].st));
            chk("pll_rst",    i, 32'(bus.pll_rst),    32'(vecs[i].prst));
            chk("domain_rst", i, 32'(bus.domain_rst), 32'(vecs[i].dom));
            chk("ready",      i, 32'(bus.ready),      32'(vecs[i].rdy));
            chk("relock_ack", i, 32'(bus.relock_ack), 32'(vecs[i].ack));
            chk("retry_cnt",  i, 32'(bus.retry_cnt),  32'(vecs[i].retry));
`ifdef PLL_LOSS_COUNTER_EN
            chk("loss_cnt",   i, 32'(bus.loss_cnt),         32'(vecs[i].loss));
            chk("sticky",     i, 32'(bus.lock_lost_sticky), 32'(vecs[i].sticky));
`endif
        end

        // Hand sequence: relock from RUN, count pll_rst cycles and ack pulses.
        bus.relock_req = 1'b1;
        step(1);
        bus.relock_req = 1'b0;
        ack_seen  = 0;
        prst_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.pll_rst) prst_seen++;
            if (bus.relock_ack) ack_seen++;
            step(1);
        end
        chk("seq_pll_rst_cycles", 100, 32'(prst_seen), 32'd4);
        chk("seq_ack_pulses",     100, 32'(ack_seen),  32'd1);
        chk("seq_final_state",    100, 32'(bus.state), 32'd4);
        chk("seq_final_ready",    100, 32'(bus.ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the core PLL on the reference clock and drives its reset.
- Waits for a qualified lock, then releases the downstream clock-domain resets in a fixed order.
- On lock loss, or when a requester asks for a relock, re-asserts all domain resets and re-runs the PLL bring-up.
- Sits between the 74.25 MHz reference clock input and every consumer of the PLL output clocks.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt (>=2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retrying.
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before release.
- RELEASE_GAP, 64: cycles between successive domain reset releases (>=1).
- N_DOMAINS, 3: number of domain reset outputs (1..8).

Ports:
- refclk  in  1  reference clock; all logic runs on it.
- rst  in  1  synchronous active-high reset.
- pll_locked  in  1  raw PLL lock, asynchronous to refclk.
- pll_rst  out  1  PLL reset, active high.
- domain_rst  out  N_DOMAINS  per-domain reset, active high, bit 0 released first.
- ready  out  1  high when all domains are released and running.
- relock_req  in  1  level request for a relock; hold until relock_ack.
- relock_ack  out  1  one-cycle pulse when a requested relock completes.
- state  out  3  current FSM state encoding.
- retry_cnt  out  4  saturating count of lock timeouts.

Behaviour:
- Reset is one clock, synchronous, active high. While rst=1:
  - state=PLL_RST (0), cnt=0, pll_rst=1, domain_rst=all ones.
  - ready=0, relock_ack=0, retry_cnt=0, pending=0.
- pll_locked passes through a 2-flop synchronizer to give locked_s, which lags by 2 cycles.
- All outputs are registered.
- pll_rst=1 exactly when state=PLL_RST. ready=1 exactly when state=RUN.
- A single cnt register is cleared on every state change.
- PLL_RST (0): cnt increments. At cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles per attempt.
- WAIT_LOCK (1):
  - locked_s=1 -> STABLE.
  - Otherwise, at cnt==LOCK_TIMEOUT-1 -> PLL_RST, and retry_cnt increments, saturating at 15.
- STABLE (2):
  - locked_s=0 -> WAIT_LOCK. The timeout restarts.
  - At cnt==LOCK_STABLE-1 -> RELEASE.
- RELEASE (3):
  - domain_rst[0] clears on the first RELEASE cycle.
  - domain_rst[k] clears k*RELEASE_GAP cycles later.
  - One cycle after the last bit clears -> RUN.
- RUN (4): ready=1. If a relock is pending on entry, relock_ack pulses on that first RUN cycle and pending clears.
- Lock loss in RELEASE or RUN (locked_s=0):
  - Next cycle: domain_rst=all ones, ready=0, state=PLL_RST.
- relock_req=1 while in RUN:
  - Same transition as lock loss, and pending is set.
  - relock_req in any other state is ignored until RUN is reached; it is acted on there because it is a level request.
- Lock loss and relock_req in the same RUN cycle are treated as a relock, so the ack is still given.
- Requester duties:
  - Drop relock_req in the cycle after relock_ack.
  - If relock_req is still high in the cycle after the ack cycle, a new relock begins.
- domain_rst bits never deassert out of order. Once any bit re-asserts, all bits re-assert together.
- retry_cnt is cleared only by rst and is not cleared on reaching RUN.
- rst mid-sequence aborts immediately to the reset values, with no partial release.
- State encoding: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN.

Optional Feature:
- Macro: PLL_LOSS_COUNTER_EN.
- When defined:
  - Adds output port loss_cnt (8 bits), a saturating count of unrequested lock losses in RELEASE or RUN, cleared by rst.
  - Adds output port lock_lost_sticky (1 bit), set on such a loss and cleared only by rst.
- When undefined: neither port exists, and the sequencing behaviour is identical.

Test Plan:
- Params 4/32/8/2/3; rst 1 for 2 cycles then 0; pll_locked rises at cycle 10 and stays high -> pll_rst high for exactly 4 cycles; STABLE entered 2 cycles after lock is seen; domain_rst goes 111 -> 110 -> 100 -> 000 at 2-cycle spacing; ready=1 one cycle after 000; retry_cnt=0.
- pll_locked held 0 -> WAIT_LOCK lasts 32 cycles, pll_rst re-pulses for 4 cycles; after 20 attempts retry_cnt=15 (saturated).
- Lock glitches low for 3 cycles at STABLE cnt=5 -> returns to WAIT_LOCK; RELEASE is reached only after a full 8-cycle clean lock; domain_rst stays 111 throughout the glitch.
- In RUN, drop pll_locked -> within 3 cycles domain_rst=111, ready=0, pll_rst=1; relock_ack never pulses; with PLL_LOSS_COUNTER_EN, loss_cnt=1 and lock_lost_sticky=1.
- In RUN, assert relock_req for 1 cycle, lock stays high -> full sequence re-runs; relock_ack is exactly one pulse, on the first RUN cycle; loss_cnt is unchanged.
- Assert rst during RELEASE after domain_rst=110 -> next cycle domain_rst=111, state=0; the sequence restarts cleanly.
